// File: rtl/conv_layer_scheduler_if.sv
`default_nettype none
// ============================================================================
// conv_layer_scheduler_if : host handshake, engine and layer-memory signals
// Revision 1.0
// ============================================================================
interface conv_layer_scheduler_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 12
);
  logic                      ready;
  logic                      busy;
  logic                      done_pulse;
  logic                      err;
  logic [1:0]                cur_layer;
  logic [2:0]                eng_start;
  logic [2:0]                eng_done;
  logic [8:0]                eng_csel;
  logic [2:0]                eng_crd;
  logic [2:0]                eng_cwr;
  logic [3*ADDR_WIDTH-1:0]   eng_caddr_rd;
  logic [3*ADDR_WIDTH-1:0]   eng_caddr_wr;
  logic [3*DATA_WIDTH-1:0]   eng_cdata_wr;
  logic [2:0]                csel;
  logic                      crd;
  logic                      cwr;
  logic [ADDR_WIDTH-1:0]     caddr_rd;
  logic [ADDR_WIDTH-1:0]     caddr_wr;
  logic [DATA_WIDTH-1:0]     cdata_wr;

  // Scheduler side
  modport master (
    input  ready, eng_done, eng_csel, eng_crd, eng_cwr,
           eng_caddr_rd, eng_caddr_wr, eng_cdata_wr,
    output busy, done_pulse, err, cur_layer, eng_start,
           csel, crd, cwr, caddr_rd, caddr_wr, cdata_wr
  );

  // Host, engines and layer memory
  modport slave (
    output ready, eng_done, eng_csel, eng_crd, eng_cwr,
           eng_caddr_rd, eng_caddr_wr, eng_cdata_wr,
    input  busy, done_pulse, err, cur_layer, eng_start,
           csel, crd, cwr, caddr_rd, caddr_wr, cdata_wr
  );
endinterface
`default_nettype wire

// File: rtl/conv_layer_scheduler.sv
`default_nettype none
// ============================================================================
// conv_layer_scheduler : sequences the L0/L1/L2 engines, grants the single
// layer-memory port to the running engine and aborts on a watchdog timeout.
// Revision 1.0
// ============================================================================
module conv_layer_scheduler #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 12,
  parameter int TO_WIDTH   = 20,
  parameter int TIMEOUT    = 600000
) (
  input wire                     clk,
  input wire                     reset,
  conv_layer_scheduler_if.master bus
);

  // RUN_Lk + 1 is always the following START state (or FINISH after L2)
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_START_L0 = 4'd1;
  localparam logic [3:0] ST_RUN_L0   = 4'd2;
  localparam logic [3:0] ST_START_L1 = 4'd3;
  localparam logic [3:0] ST_RUN_L1   = 4'd4;
  localparam logic [3:0] ST_START_L2 = 4'd5;
  localparam logic [3:0] ST_RUN_L2   = 4'd6;
  localparam logic [3:0] ST_FINISH   = 4'd7;
  localparam logic [3:0] ST_ERROR    = 4'd8;

  localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'(TIMEOUT - 1);

  logic [3:0]          state_q, state_d;
  logic [TO_WIDTH-1:0] wd_q, wd_d;
  logic                err_q, err_d;

  logic                busy;
  logic                done_pulse;
  logic [2:0]          eng_start;
  logic [1:0]          layer;
  logic                run;

  logic [2:0]            eng_csel_a [3];
  logic [ADDR_WIDTH-1:0] eng_rd_a   [3];
  logic [ADDR_WIDTH-1:0] eng_wr_a   [3];
  logic [DATA_WIDTH-1:0] eng_dat_a  [3];

  logic [2:0]            csel;
  logic                  crd;
  logic                  cwr;
  logic [ADDR_WIDTH-1:0] caddr_rd;
  logic [ADDR_WIDTH-1:0] caddr_wr;
  logic [DATA_WIDTH-1:0] cdata_wr;

  generate
    for (genvar k = 0; k < 3; k++) begin : g_eng
      assign eng_csel_a[k] = bus.eng_csel[3*k +: 3];
      assign eng_rd_a[k]   = bus.eng_caddr_rd[ADDR_WIDTH*k +: ADDR_WIDTH];
      assign eng_wr_a[k]   = bus.eng_caddr_wr[ADDR_WIDTH*k +: ADDR_WIDTH];
      assign eng_dat_a[k]  = bus.eng_cdata_wr[DATA_WIDTH*k +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (bus.ready) begin
          state_d = ST_START_L0;
          err_d   = 1'b0;
        end
      end
      ST_START_L0, ST_START_L1, ST_START_L2: begin
        state_d = state_q + 4'd1;
        wd_d    = '0;
      end
      ST_RUN_L0, ST_RUN_L1, ST_RUN_L2: begin
        // A done arriving on the last watchdog cycle still counts as success
        if (bus.eng_done[layer]) begin
          state_d = state_q + 4'd1;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + TO_WIDTH'(1);
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done_pulse = 1'b0;
    eng_start  = 3'b000;
    layer      = 2'd3;
    run        = 1'b0;
    case (state_q)
      ST_START_L0: begin busy = 1'b1; layer = 2'd0; eng_start = 3'b001; end
      ST_RUN_L0:   begin busy = 1'b1; layer = 2'd0; run = 1'b1;         end
      ST_START_L1: begin busy = 1'b1; layer = 2'd1; eng_start = 3'b010; end
      ST_RUN_L1:   begin busy = 1'b1; layer = 2'd1; run = 1'b1;         end
      ST_START_L2: begin busy = 1'b1; layer = 2'd2; eng_start = 3'b100; end
      ST_RUN_L2:   begin busy = 1'b1; layer = 2'd2; run = 1'b1;         end
      ST_FINISH:   done_pulse = 1'b1;
      default:     ;
    endcase
  end

  // Only the running engine reaches the memory; a write beats a read
  always_comb begin
    csel     = '0;
    crd      = 1'b0;
    cwr      = 1'b0;
    caddr_rd = '0;
    caddr_wr = '0;
    cdata_wr = '0;
    if (run) begin
      csel     = eng_csel_a[layer];
      cwr      = bus.eng_cwr[layer];
      crd      = bus.eng_crd[layer] & ~bus.eng_cwr[layer];
      caddr_rd = eng_rd_a[layer];
      caddr_wr = eng_wr_a[layer];
      cdata_wr = eng_dat_a[layer];
    end
  end

  assign bus.busy       = busy;
  assign bus.done_pulse = done_pulse;
  assign bus.err        = err_q;
  assign bus.cur_layer  = layer;
  assign bus.eng_start  = eng_start;
  assign bus.csel       = csel;
  assign bus.crd        = crd;
  assign bus.cwr        = cwr;
  assign bus.caddr_rd   = caddr_rd;
  assign bus.caddr_wr   = caddr_wr;
  assign bus.cdata_wr   = cdata_wr;

endmodule
`default_nettype wire
